// File: rtl/mem_stage_wb.sv
// MEM stage with a data-memory handshake FSM (IDLE/ACCESS/ABORT), branch/jump resolution and the MEM/WB register.
// Optional feature macro: MEM_SUBWORD_EN enables byte/halfword loads and stores.
module mem_stage_wb #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_read_rb_2,
   input  logic [31:0] i_branch_address,
   input  logic [31:0] i_jump_address,
   input  logic [4:0]  i_inst_mux_br_write_address,
   input  logic        i_zf,
   input  logic        i_branch,
   input  logic        i_memWrite,
   input  logic        i_regWrite,
   input  logic        i_memToReg,
   input  logic        i_jump,
   input  logic [1:0]  i_memRead,
   input  logic [5:0]  i_opcode,
   output logic        o_dm_req,
   output logic        o_dm_we,
   output logic [31:0] o_dm_addr,
   output logic [31:0] o_dm_wdata,
   output logic [3:0]  o_dm_be,
   input  logic        i_dm_ack,
   input  logic [31:0] i_dm_rdata,
   output logic [1:0]  o_pc_src,
   output logic [31:0] o_pc_target,
   output logic        o_flush,
   output logic        o_stall,
   output logic [31:0] o_rd_data,
   output logic [31:0] o_alu_result,
   output logic [4:0]  o_write_address,
   output logic        o_regWrite,
   output logic        o_memToReg,
   output logic        o_mem_err,
   output logic [1:0]  o_dbg_state
);

   // Handshake: o_dm_req stays high for every ACCESS cycle; a transfer completes in the
   // cycle where o_dm_req and i_dm_ack are both high. Ack outside ACCESS is ignored.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ABORT  = 2'd2
   } state_t;

   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;
   localparam logic [5:0] OP_BNE  = 6'b000101;
`ifdef MEM_SUBWORD_EN
   localparam logic [5:0] OP_LBU  = 6'b100100;
   localparam logic [5:0] OP_LHU  = 6'b100101;
   localparam logic [5:0] OP_SB   = 6'b101000;
   localparam logic [5:0] OP_SH   = 6'b101001;
`endif

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_cnt;
   logic           w_mem_op;
   logic           w_misaligned;
   logic [1:0]     w_size;
   logic [3:0]     w_be;
   logic [31:0]    w_wdata;
   logic [31:0]    w_load_data;
   logic           w_stall;
   logic           w_req;
   logic           w_err;
   logic           w_taken;

   assign w_mem_op = (i_memRead != 2'b00) || i_memWrite;

   // Stores win over loads, so a store's width comes from its opcode.
   always_comb begin
      w_size = SZ_WORD;
`ifdef MEM_SUBWORD_EN
      if (i_memWrite) begin
         if (i_opcode == OP_SB)      w_size = SZ_BYTE;
         else if (i_opcode == OP_SH) w_size = SZ_HALF;
      end else if (i_memRead == 2'b10) begin
         w_size = SZ_BYTE;
      end else if (i_memRead == 2'b11) begin
         w_size = SZ_HALF;
      end
`endif
   end

   assign w_misaligned = w_mem_op &&
                         (((w_size == SZ_WORD) && (i_alu_result[1:0] != 2'b00)) ||
                          ((w_size == SZ_HALF) && i_alu_result[0]));

   always_comb begin
      w_be        = 4'b1111;
      w_wdata     = i_read_rb_2;
      w_load_data = i_dm_rdata;
`ifdef MEM_SUBWORD_EN
      case (w_size)
         SZ_BYTE: begin
            w_be    = 4'b0001 << i_alu_result[1:0];
            w_wdata = {4{i_read_rb_2[7:0]}};
            if (i_opcode == OP_LBU)
               w_load_data = {24'd0, i_dm_rdata[{i_alu_result[1:0], 3'b000} +: 8]};
            else
               w_load_data = {{24{i_dm_rdata[{i_alu_result[1:0], 3'b111}]}},
                              i_dm_rdata[{i_alu_result[1:0], 3'b000} +: 8]};
         end
         SZ_HALF: begin
            w_be    = i_alu_result[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_read_rb_2[15:0]}};
            if (i_opcode == OP_LHU)
               w_load_data = {16'd0, i_alu_result[1] ? i_dm_rdata[31:16] : i_dm_rdata[15:0]};
            else
               w_load_data = i_alu_result[1] ? {{16{i_dm_rdata[31]}}, i_dm_rdata[31:16]}
                                             : {{16{i_dm_rdata[15]}}, i_dm_rdata[15:0]};
         end
         default: ;
      endcase
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      w_req   = 1'b0;
      w_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op) begin
               if (w_misaligned) begin
                  w_err = 1'b1;
               end else begin
                  w_stall = 1'b1;
                  w_next  = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            w_req = 1'b1;
            if (i_dm_ack) begin
               w_next = S_IDLE;
            end else begin
               w_stall = 1'b1;
               if (r_cnt == CW'(ACK_TIMEOUT - 1)) w_next = S_ABORT;
            end
         end
         S_ABORT: begin
            w_err  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Counts ACCESS cycles spent without an ack; restarts on every new access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     r_cnt <= '0;
      else if (r_state != S_ACCESS) r_cnt <= '0;
      else if (!i_dm_ack)          r_cnt <= r_cnt + CW'(1);
   end

   assign o_stall     = w_stall;
   assign o_dm_req    = w_req;
   assign o_dm_we     = w_req && i_memWrite;
   assign o_dm_addr   = w_req ? i_alu_result : 32'd0;
   assign o_dm_wdata  = w_req ? w_wdata : 32'd0;
   assign o_dm_be     = w_req ? w_be : 4'd0;
   assign o_dbg_state = r_state;

   assign w_taken = (i_opcode == OP_BNE) ? !i_zf : i_zf;

   always_comb begin
      o_pc_src    = 2'b00;
      o_pc_target = 32'd0;
      if (i_jump) begin
         o_pc_src    = 2'b10;
         o_pc_target = i_jump_address;
      end else if (i_branch && w_taken) begin
         o_pc_src    = 2'b01;
         o_pc_target = i_branch_address;
      end
   end

   assign o_flush = (o_pc_src != 2'b00) && !w_stall;

   // Stalled cycles insert a bubble; error cycles write nothing but flag o_mem_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_rd_data       <= 32'd0;
         o_alu_result    <= 32'd0;
         o_write_address <= 5'd0;
         o_regWrite      <= 1'b0;
         o_memToReg      <= 1'b0;
         o_mem_err       <= 1'b0;
      end else if (w_stall) begin
         o_regWrite <= 1'b0;
         o_mem_err  <= 1'b0;
      end else begin
         o_alu_result    <= i_alu_result;
         o_write_address <= i_inst_mux_br_write_address;
         o_memToReg      <= i_memToReg;
         if (w_err) begin
            o_regWrite <= 1'b0;
            o_mem_err  <= 1'b1;
         end else begin
            o_regWrite <= i_regWrite && !i_memWrite;
            o_mem_err  <= 1'b0;
            if ((r_state == S_ACCESS) && !i_memWrite) o_rd_data <= w_load_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Bench for mem_stage_wb: directed scenarios plus randomized instructions checked against a cycle-count model.
module tb_mem_stage_wb;
   localparam int T = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_alu_result, i_read_rb_2, i_branch_address, i_jump_address;
   logic [4:0]  i_inst_mux_br_write_address;
   logic        i_zf, i_branch, i_memWrite, i_regWrite, i_memToReg, i_jump;
   logic [1:0]  i_memRead;
   logic [5:0]  i_opcode;
   logic        o_dm_req, o_dm_we;
   logic [31:0] o_dm_addr, o_dm_wdata;
   logic [3:0]  o_dm_be;
   logic        i_dm_ack;
   logic [31:0] i_dm_rdata;
   logic [1:0]  o_pc_src;
   logic [31:0] o_pc_target;
   logic        o_flush, o_stall;
   logic [31:0] o_rd_data, o_alu_result;
   logic [4:0]  o_write_address;
   logic        o_regWrite, o_memToReg, o_mem_err;
   logic [1:0]  o_dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   mem_stage_wb #(.ACK_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .i_alu_result(i_alu_result), .i_read_rb_2(i_read_rb_2),
      .i_branch_address(i_branch_address), .i_jump_address(i_jump_address),
      .i_inst_mux_br_write_address(i_inst_mux_br_write_address),
      .i_zf(i_zf), .i_branch(i_branch), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
      .i_memToReg(i_memToReg), .i_jump(i_jump), .i_memRead(i_memRead), .i_opcode(i_opcode),
      .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata),
      .o_dm_be(o_dm_be), .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata),
      .o_pc_src(o_pc_src), .o_pc_target(o_pc_target), .o_flush(o_flush), .o_stall(o_stall),
      .o_rd_data(o_rd_data), .o_alu_result(o_alu_result), .o_write_address(o_write_address),
      .o_regWrite(o_regWrite), .o_memToReg(o_memToReg), .o_mem_err(o_mem_err),
      .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int ref_size(logic [1:0] mr, logic mw, logic [5:0] op);
`ifdef MEM_SUBWORD_EN
      if (mw) return (op == 6'h28) ? 1 : (op == 6'h29) ? 2 : 4;
      return (mr == 2'b10) ? 1 : (mr == 2'b11) ? 2 : 4;
`else
      return 4;
`endif
   endfunction

   function automatic logic [3:0] ref_be(logic [31:0] addr, int size);
      int mask;
      if (size == 4) return 4'hF;
      mask = ((1 << size) - 1) << (addr % 4);
      return mask[3:0];
   endfunction

   function automatic logic [31:0] ref_wdata(logic [31:0] d, int size);
      if (size == 1) return d[7:0] * 32'h0101_0101;
      if (size == 2) return d[15:0] * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(logic [31:0] rd, logic [31:0] addr, int size, logic [5:0] op);
      logic [31:0] v;
      v = rd >> (8 * (addr % 4));
      if (size == 1) begin
         v = v & 32'hFF;
         if (op != 6'h24 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
         v = v & 32'hFFFF;
         if (op != 6'h25 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [1:0] ref_pc_src(logic jp, logic br, logic zf, logic [5:0] op);
      if (jp) return 2'b10;
      if (br && ((op == 6'h05) ? !zf : zf)) return 2'b01;
      return 2'b00;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_nop();
      i_alu_result = 32'd0; i_read_rb_2 = 32'd0; i_branch_address = 32'd0; i_jump_address = 32'd0;
      i_inst_mux_br_write_address = 5'd0; i_zf = 1'b0; i_branch = 1'b0; i_memWrite = 1'b0;
      i_regWrite = 1'b0; i_memToReg = 1'b0; i_jump = 1'b0; i_memRead = 2'b00; i_opcode = 6'd0;
      i_dm_ack = 1'b0; i_dm_rdata = 32'd0;
   endtask

   // Drives one instruction (called at posedge+1), holds it while stalled, and checks
   // every cycle plus the MEM/WB result. ack_delay >= T means the memory never acks.
   task automatic run_instr(input string tag, input logic [31:0] alu, input logic [31:0] sd,
                            input logic [4:0] rd, input logic rw, input logic [1:0] mr,
                            input logic mw, input logic mtr, input logic [5:0] op,
                            input logic zf, input logic br, input logic jp,
                            input logic [31:0] ba, input logic [31:0] ja,
                            input int ack_delay, input logic [31:0] rdata);
      int size, exp_stall_n, last_k, req_last;
      logic memop, mis, tmo, e_stall, e_req, e_flush;
      logic [1:0] e_pc;
      i_alu_result = alu; i_read_rb_2 = sd; i_inst_mux_br_write_address = rd; i_regWrite = rw;
      i_memRead = mr; i_memWrite = mw; i_memToReg = mtr; i_opcode = op; i_zf = zf;
      i_branch = br; i_jump = jp; i_branch_address = ba; i_jump_address = ja;
      memop = (mr != 2'b00) || mw;
      size = ref_size(mr, mw, op);
      mis = memop && ((alu % size) != 0);
      tmo = memop && !mis && (ack_delay >= T);
      exp_stall_n = (!memop || mis) ? 0 : (tmo ? 1 + T : 1 + ack_delay);
      last_k = exp_stall_n;
      req_last = tmo ? T : ack_delay + 1;
      e_pc = ref_pc_src(jp, br, zf, op);
      for (int k = 0; k <= last_k; k++) begin
         i_dm_rdata = $urandom();
         i_dm_ack = 1'b0;
         if (memop && !mis && ((!tmo && k == ack_delay + 1) || (tmo && k == last_k))) begin
            i_dm_ack = 1'b1;
            i_dm_rdata = rdata;
         end
         #1;
         e_stall = (k < exp_stall_n);
         e_req = memop && !mis && (k >= 1) && (k <= req_last);
         e_flush = (e_pc != 2'b00) && !e_stall;
         n_checks++;
         if (o_stall !== e_stall) $display("FAIL %s stall k=%0d got %b want %b", tag, k, o_stall, e_stall);
         else n_pass++;
         n_checks++;
         if (o_dm_req !== e_req) $display("FAIL %s dm_req k=%0d got %b want %b", tag, k, o_dm_req, e_req);
         else n_pass++;
         n_checks++;
         if (o_pc_src !== e_pc || o_flush !== e_flush)
            $display("FAIL %s pc k=%0d got src=%b flush=%b want src=%b flush=%b", tag, k, o_pc_src, o_flush, e_pc, e_flush);
         else n_pass++;
         if (e_pc != 2'b00) begin
            n_checks++;
            if (o_pc_target !== (jp ? ja : ba)) $display("FAIL %s pc_target got %h want %h", tag, o_pc_target, jp ? ja : ba);
            else n_pass++;
         end
         if (e_req) begin
            n_checks++;
            if (o_dm_addr !== alu || o_dm_we !== mw || o_dm_be !== ref_be(alu, size) ||
                (mw && o_dm_wdata !== ref_wdata(sd, size)))
               $display("FAIL %s dm_bus k=%0d got a=%h we=%b be=%b wd=%h want a=%h we=%b be=%b wd=%h", tag, k,
                        o_dm_addr, o_dm_we, o_dm_be, o_dm_wdata, alu, mw, ref_be(alu, size), ref_wdata(sd, size));
            else n_pass++;
         end
         if (k >= 1) begin
            n_checks++;
            if (o_regWrite !== 1'b0 || o_mem_err !== 1'b0)
               $display("FAIL %s bubble k=%0d got rw=%b err=%b want 0 0", tag, k, o_regWrite, o_mem_err);
            else n_pass++;
         end
         @(posedge clk); #1;
      end
      i_dm_ack = 1'b0;
      if (mis || tmo) begin
         n_checks++;
         if (o_regWrite !== 1'b0 || o_mem_err !== 1'b1)
            $display("FAIL %s err_wb got rw=%b err=%b want 0 1", tag, o_regWrite, o_mem_err);
         else n_pass++;
      end else begin
         n_checks++;
         if (o_regWrite !== (rw && !mw) || o_mem_err !== 1'b0 || o_alu_result !== alu ||
             o_write_address !== rd || o_memToReg !== mtr)
            $display("FAIL %s wb got rw=%b err=%b alu=%h rd=%0d m2r=%b want %b 0 %h %0d %b", tag, o_regWrite,
                     o_mem_err, o_alu_result, o_write_address, o_memToReg, rw && !mw, alu, rd, mtr);
         else n_pass++;
         if (mr != 2'b00 && !mw) begin
            n_checks++;
            if (o_rd_data !== ref_load(rdata, alu, size, op))
               $display("FAIL %s rd_data got %h want %h", tag, o_rd_data, ref_load(rdata, alu, size, op));
            else n_pass++;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_checks++;
      if (o_dm_req !== 1'b0 || o_regWrite !== 1'b0 || o_memToReg !== 1'b0 || o_mem_err !== 1'b0 ||
          o_rd_data !== 32'd0 || o_alu_result !== 32'd0 || o_write_address !== 5'd0 || o_stall !== 1'b0)
         $display("FAIL reset got req=%b rw=%b m2r=%b err=%b rd=%h alu=%h wa=%0d stall=%b want all 0", o_dm_req,
                  o_regWrite, o_memToReg, o_mem_err, o_rd_data, o_alu_result, o_write_address, o_stall);
      else n_pass++;
   endtask

   task automatic test_rtype();
      run_instr("rtype", 32'h10, 32'h0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
   endtask

   task automatic test_load_store();
      run_instr("lw", 32'h100, 32'h0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b1, 6'h23, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3, 32'hDEADBEEF);
      run_instr("sw_tmo", 32'h104, 32'h1234_5678, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, T + 5, 32'h0);
      run_instr("after_err", 32'h55, 32'h0, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      run_instr("sw_ack0", 32'h108, 32'hCAFE_F00D, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      run_instr("lw_last", 32'h10C, 32'h0, 5'd3, 1'b1, 2'b01, 1'b0, 1'b1, 6'h23, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, T - 1, 32'h0BAD_F00D);
      run_instr("write_wins", 32'h110, 32'h0F0F_0F0F, 5'd4, 1'b1, 2'b01, 1'b1, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);
      run_instr("lw_mis", 32'h202, 32'h0, 5'd6, 1'b1, 2'b01, 1'b0, 1'b1, 6'h23, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
   endtask

   task automatic test_branch_jump();
      run_instr("beq_jump", 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 6'h04, 1'b1, 1'b1, 1'b1, 32'h40, 32'h80, 0, 32'h0);
      run_instr("beq_taken", 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 6'h04, 1'b1, 1'b1, 1'b0, 32'h40, 32'h80, 0, 32'h0);
      run_instr("beq_nt", 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 6'h04, 1'b0, 1'b1, 1'b0, 32'h40, 32'h80, 0, 32'h0);
      run_instr("bne_taken", 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 6'h05, 1'b0, 1'b1, 1'b0, 32'h44, 32'h80, 0, 32'h0);
      run_instr("bne_nt", 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 6'h05, 1'b1, 1'b1, 1'b0, 32'h44, 32'h80, 0, 32'h0);
      run_instr("jump_in_lw", 32'h120, 32'h0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b1, 6'h23, 1'b0, 1'b0, 1'b1, 32'h0, 32'h90, 2, 32'h7777_0001);
   endtask

   task automatic test_subword();
`ifdef MEM_SUBWORD_EN
      run_instr("lb", 32'h203, 32'h0, 5'd8, 1'b1, 2'b10, 1'b0, 1'b1, 6'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h8012_3456);
      run_instr("lbu", 32'h201, 32'h0, 5'd8, 1'b1, 2'b10, 1'b0, 1'b1, 6'h24, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0000_F100);
      run_instr("lh", 32'h202, 32'h0, 5'd8, 1'b1, 2'b11, 1'b0, 1'b1, 6'h21, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h9ABC_0000);
      run_instr("lhu", 32'h200, 32'h0, 5'd8, 1'b1, 2'b11, 1'b0, 1'b1, 6'h25, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0000_8001);
      run_instr("lh_mis", 32'h201, 32'h0, 5'd8, 1'b1, 2'b11, 1'b0, 1'b1, 6'h21, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      run_instr("sb", 32'h302, 32'h1122_33A5, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 6'h28, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      run_instr("sh", 32'h302, 32'h1122_B3A5, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 6'h29, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);
`else
      run_instr("lb_as_word", 32'h200, 32'h0, 5'd8, 1'b1, 2'b10, 1'b0, 1'b1, 6'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h8012_3456);
      run_instr("lh_as_word", 32'h204, 32'h0, 5'd8, 1'b1, 2'b11, 1'b0, 1'b1, 6'h21, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h9ABC_0123);
      run_instr("lb_mis_word", 32'h203, 32'h0, 5'd8, 1'b1, 2'b10, 1'b0, 1'b1, 6'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
`endif
   endtask

   task automatic test_reset_mid_access();
      run_instr("pre_rst", 32'h10, 32'h0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      i_alu_result = 32'h100; i_memRead = 2'b01; i_regWrite = 1'b1; i_opcode = 6'h23;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (o_dm_req !== 1'b1) $display("FAIL rst_mid pre_req got %b want 1", o_dm_req);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (o_dm_req !== 1'b0 || o_regWrite !== 1'b0 || o_alu_result !== 32'd0 || o_write_address !== 5'd0 ||
          o_memToReg !== 1'b0 || o_mem_err !== 1'b0 || o_rd_data !== 32'd0)
         $display("FAIL rst_mid outputs got req=%b rw=%b alu=%h wa=%0d m2r=%b err=%b rd=%h want all 0", o_dm_req,
                  o_regWrite, o_alu_result, o_write_address, o_memToReg, o_mem_err, o_rd_data);
      else n_pass++;
      set_nop();
      i_alu_result = 32'h33; i_regWrite = 1'b1; i_inst_mux_br_write_address = 5'd11;
      @(posedge clk); #1;
      rst = 1'b0;
      i_dm_ack = 1'b1; i_dm_rdata = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if (o_stall !== 1'b0 || o_dm_req !== 1'b0) $display("FAIL rst_late_ack got stall=%b req=%b want 0 0", o_stall, o_dm_req);
      else n_pass++;
      @(posedge clk); #1;
      i_dm_ack = 1'b0;
      n_checks++;
      if (o_regWrite !== 1'b1 || o_alu_result !== 32'h33 || o_write_address !== 5'd11 || o_mem_err !== 1'b0)
         $display("FAIL rst_after_wb got rw=%b alu=%h wa=%0d err=%b want 1 00000033 11 0", o_regWrite, o_alu_result,
                  o_write_address, o_mem_err);
      else n_pass++;
   endtask

   task automatic test_random(input int n);
      logic [1:0] mr;
      logic mw;
      logic [5:0] op;
      logic [31:0] addr;
      int kind, sz, dly;
      for (int i = 0; i < n; i++) begin
         kind = $urandom_range(0, 9);
         mr = 2'b00; mw = 1'b0; op = 6'h00;
         case (kind)
            0: begin mr = 2'b01; op = 6'h23; end
            1: begin mr = 2'b10; op = 6'h20; end
            2: begin mr = 2'b10; op = 6'h24; end
            3: begin mr = 2'b11; op = 6'h21; end
            4: begin mr = 2'b11; op = 6'h25; end
            5: begin mw = 1'b1; op = 6'h2B; end
            6: begin mw = 1'b1; op = 6'h28; end
            7: begin mw = 1'b1; op = 6'h29; end
            8: op = 6'h05;
            default: op = 6'h04;
         endcase
         sz = ref_size(mr, mw, op);
         addr = $urandom();
         if ($urandom_range(0, 7) != 0) addr = addr - (addr % sz);
         dly = ($urandom_range(0, 9) == 0) ? T + 1 : $urandom_range(0, 4);
         run_instr("random", addr, $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), mr, mw,
                   1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), $urandom(), $urandom(), dly, $urandom());
      end
   endtask

   initial begin
      rst = 1'b1;
      set_nop();
      #2;
      test_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      test_reset();
      test_rtype();
      test_load_store();
      test_branch_jump();
      test_subword();
      test_reset_mid_access();
      test_random(40);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_stage_wb.md
MEM_STAGE_WB -- requirements
Module: mem_stage_wb

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, max cycles waiting for i_dm_ack before abort.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_alu_result  in  32  EX/MEM ALU result / memory address.
REQ-005 i_read_rb_2  in  32  EX/MEM store data.
REQ-006 i_branch_address, i_jump_address  in  32 each  EX/MEM targets.
REQ-007 i_inst_mux_br_write_address  in  5  destination register.
REQ-008 i_zf, i_branch, i_memWrite, i_regWrite, i_memToReg, i_jump  in  1 each  EX/MEM flags/controls.
REQ-009 i_memRead  in  2  00 none, 01 word, 10 byte, 11 half; i_opcode  in  6.
REQ-010 o_dm_req, o_dm_we  out  1; o_dm_addr, o_dm_wdata  out  32; o_dm_be  out  4  data-memory request.
REQ-011 i_dm_ack  in  1; i_dm_rdata  in  32  memory response.
REQ-012 o_pc_src  out  2 (00 seq, 01 branch, 10 jump); o_pc_target  out  32; o_flush  out  1.
REQ-013 o_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-014 o_rd_data, o_alu_result  out  32; o_write_address  out  5; o_regWrite, o_memToReg, o_mem_err  out  1  MEM/WB register.

Function
REQ-015 FSM states IDLE, ACCESS, ABORT; mem op = i_memRead!=00 or i_memWrite.
REQ-016 IDLE: mem op -> ACCESS next edge; otherwise stay.
REQ-017 ACCESS: o_dm_req=1, addr/wdata/we/be driven from inputs; i_dm_ack -> IDLE; ACK_TIMEOUT cycles without ack -> ABORT.
REQ-018 ABORT lasts exactly one cycle, then IDLE; ack arriving in ABORT ignored.
REQ-019 o_stall = (IDLE and mem op) or (ACCESS and not i_dm_ack); combinational.
REQ-020 EX/MEM inputs are held stable by upstream while o_stall=1.
REQ-021 MEM/WB register loads inputs when o_stall=0; during stall loads bubble (o_regWrite=0, others hold).
REQ-022 Non-memory op: 1-cycle latency to MEM/WB outputs; load: o_rd_data = i_dm_rdata captured on ack edge.
REQ-023 Abort or misaligned access: MEM/WB loads with o_regWrite=0 and o_mem_err=1 for one cycle; o_mem_err=0 otherwise.
REQ-024 Misaligned (word addr[1:0]!=0, half addr[0]!=0): no request issued, direct IDLE->error bubble, o_stall=0 that cycle.
REQ-025 o_pc_src: i_jump -> 10 (target i_jump_address), priority over branch; i_branch and taken -> 01 (i_branch_address); else 00.
REQ-026 Taken = i_zf, except opcode 000101 (bne) taken = !i_zf.
REQ-027 o_flush = (o_pc_src!=00) and o_stall=0.
REQ-028 o_dm_we=1 only when i_memWrite; read and write both set -> write wins, no register write.

Reset
REQ-029 rst: state IDLE, timeout counter 0, all MEM/WB outputs 0, o_dm_req 0, effective immediately.
REQ-030 Reset mid-ACCESS drops o_dm_req same cycle; pending ack after reset ignored.

Configuration
REQ-031 Macro MEM_SUBWORD_EN defined: byte/half loads, be from addr[1:0], sign-extend except lbu 100100 / lhu 100101 zero-extend; sb 101000 / sh 101001 replicate data, partial be.
REQ-032 MEM_SUBWORD_EN undefined: every access is word, o_dm_be=1111, i_memRead 10/11 treated as 01.

Verification
REQ-033 R-type, no mem op, alu 0x0000_0010, rd 5 -> next cycle o_alu_result 0x10, o_regWrite 1, o_stall never 1.
REQ-034 lw addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> o_stall 4 cycles, o_rd_data 0xDEADBEEF, bubbles meanwhile.
REQ-035 sw addr 0x104, no ack -> ABORT after 15 cycles, o_mem_err pulse 1 cycle, o_regWrite 0.
REQ-036 beq zf=1 target 0x40 and i_jump=1 target 0x80 -> o_pc_src 10, o_pc_target 0x80, o_flush 1.
REQ-037 lb (MEM_SUBWORD_EN) addr 0x203, rdata 0x80xxxxxx -> o_dm_be 1000, o_rd_data 0xFFFFFF80; lw addr 0x202 -> o_mem_err, no o_dm_req.
REQ-038 rst asserted in ACCESS cycle 2 -> o_dm_req 0 immediately, outputs 0, later ack ignored.
